mem_port_arbiter: RTL

//  Shares the single-port unified instruction/data memory between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_map_pkg.sv | 17 +
 rtl/addr_xlate.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - memory map defaults, requester ids and arbiter state encoding
package mem_map_pkg;

    localparam logic [31:0] DEF_TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DEF_DATA_BASE = 32'h1001_0000;

    typedef logic id_t;
    localparam id_t ID_IF = 1'b0;
    localparam id_t ID_LS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/addr_xlate.sv
// rtl/addr_xlate.sv - byte address to memory word index with window and access-type fault checks
module addr_xlate
    import mem_map_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] TEXT_BASE  = DEF_TEXT_BASE,
    parameter logic [ADDR_WIDTH-1:0] DATA_BASE  = DEF_DATA_BASE,
    parameter int                    TEXT_WORDS = 64,
    parameter int                    DATA_WORDS = 64,
    parameter int                    MAW        = $clog2(TEXT_WORDS + DATA_WORDS)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  is_store,
    input  logic                  is_fetch,
    output logic [MAW-1:0]        idx,
    output logic                  fault
);

    localparam logic [ADDR_WIDTH-1:0] TEXT_BYTES = ADDR_WIDTH'(4 * TEXT_WORDS);
    localparam logic [ADDR_WIDTH-1:0] DATA_BYTES = ADDR_WIDTH'(4 * DATA_WORDS);
    localparam logic [MAW-1:0]        DATA_FIRST = MAW'(TEXT_WORDS);

    logic [ADDR_WIDTH-1:0] text_off;
    logic [ADDR_WIDTH-1:0] data_off;
    logic                  in_text;
    logic                  in_data;
    logic                  misaligned;

    // Offsets wrap for addresses below a base, so a single unsigned compare bounds both ends.
    always_comb begin
        text_off   = addr - TEXT_BASE;
        data_off   = addr - DATA_BASE;
        in_text    = text_off < TEXT_BYTES;
        in_data    = data_off < DATA_BYTES;
        misaligned = addr[1:0] != 2'b00;
        fault      = misaligned | ~(in_text | in_data) | (is_fetch & in_data) | (is_store & in_text);
        idx        = in_text ? text_off[MAW+1:2] : DATA_FIRST + data_off[MAW+1:2];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store requesters
module mem_port_arbiter
    import mem_map_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] TEXT_BASE    = DEF_TEXT_BASE,
    parameter logic [ADDR_WIDTH-1:0] DATA_BASE    = DEF_DATA_BASE,
    parameter int                    TEXT_WORDS   = 64,
    parameter int                    DATA_WORDS   = 64,
    parameter int                    STARVE_LIMIT = 4,
    localparam int                   MAW          = $clog2(TEXT_WORDS + DATA_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MAW-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int             SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

    state_t                  state;
    logic [SW-1:0]           starve_cnt;
    id_t                     lat_id;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;

    logic                    x_store;
    logic                    x_fetch;
    logic [MAW-1:0]          x_idx;
    logic                    x_fault;
    logic                    force_if;
    logic                    pick_ls;
    logic                    pick_if;
    logic [DATA_WIDTH-1:0]   resp_data;

    assign x_store = (lat_id == ID_LS) & lat_we;
    assign x_fetch = (lat_id == ID_IF);

    addr_xlate #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .TEXT_BASE  (TEXT_BASE),
        .DATA_BASE  (DATA_BASE),
        .TEXT_WORDS (TEXT_WORDS),
        .DATA_WORDS (DATA_WORDS),
        .MAW        (MAW)
    ) u_xlate (
        .addr     (lat_addr),
        .is_store (x_store),
        .is_fetch (x_fetch),
        .idx      (x_idx),
        .fault    (x_fault)
    );

    // LS has priority until IF has watched STARVE_LIMIT LS grants go by.
    assign force_if  = if_req & (starve_cnt == STARVE_MAX);
    assign pick_ls   = ls_req & ~force_if;
    assign pick_if   = if_req & ~pick_ls;

    // The latched address stays stable through WAIT, so the fault flag is still valid there.
    assign resp_data = (x_fault | lat_we) ? '0 : mem_rdata;

    assign mem_en    = (state == ST_ISSUE) & ~x_fault;
    assign mem_we    = mem_en & lat_we;
    assign mem_addr  = mem_en ? x_idx : '0;
    assign mem_wdata = mem_we ? lat_wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            lat_id     <= ID_IF;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            ls_gnt     <= 1'b0;
            ls_rvalid  <= 1'b0;
            ls_rdata   <= '0;
            ls_err     <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            if_err    <= 1'b0;
            ls_err    <= 1'b0;
            if (!if_req) begin
                starve_cnt <= '0;
            end
            case (state)
                ST_ISSUE: state <= ST_WAIT;
                default: begin
                    if (state == ST_WAIT) begin
                        if (lat_id == ID_LS) begin
                            ls_rvalid <= 1'b1;
                            ls_err    <= x_fault;
                            ls_rdata  <= resp_data;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_err    <= x_fault;
                            if_rdata  <= resp_data;
                        end
                    end
                    if (pick_ls || pick_if) begin
                        state     <= ST_ISSUE;
                        lat_id    <= pick_ls ? ID_LS : ID_IF;
                        lat_we    <= pick_ls & ls_we;
                        lat_addr  <= pick_ls ? ls_addr : if_addr;
                        lat_wdata <= ls_wdata;
                        if_gnt    <= pick_if;
                        ls_gnt    <= pick_ls;
                        if (pick_if) begin
                            starve_cnt <= '0;
                        end else if (if_req && starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
